// File: rtl/ibex_vector_conv_pkg.sv
// Shared types, sharpen preset and the shift/clamp helper for the vector convolution unit.
package ibex_vector_conv_pkg;

   typedef enum logic [1:0] {
      MODE_BANK     = 2'd0,
      MODE_SELECT   = 2'd1,
      MODE_SHARPEN  = 2'd2,
      MODE_BANK_ALT = 2'd3
   } conv_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } conv_state_e;

   localparam int SHARPEN_TAPS = 9;
   localparam int SHARPEN_W    = 8;

   // Tap t lives at [t*8 +: 8]; centre +5, edge neighbours -1, corners 0.
   localparam logic [SHARPEN_TAPS*SHARPEN_W-1:0] SHARPEN_3X3 = 72'h00_FF_00_FF_05_FF_00_FF_00;

   // Returns {value[31:0], sat} so callers can keep just the low PIX_W+1 bits.
   function automatic logic [32:0] shift_clamp(input logic signed [63:0] acc,
                                               input logic [4:0]         shamt,
                                               input int unsigned        pix_w);
      logic signed [63:0] shifted;
      logic signed [63:0] max_pix;
      logic [32:0]        res;
      shifted = acc >>> shamt;
      max_pix = (64'sd1 <<< pix_w) - 64'sd1;
      if (shifted < 64'sd0) begin
         res = {32'd0, 1'b1};
      end else if (shifted > max_pix) begin
         res = {max_pix[31:0], 1'b1};
      end else begin
         res = {shifted[31:0], 1'b0};
      end
      return res;
   endfunction

endpackage

// File: rtl/ibex_vector_conv_lane.sv
// One multiply lane: unsigned pixel times signed coefficient, sign-extended to the accumulator width.
module ibex_vector_conv_lane #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic        [PIX_W-1:0]  pix,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0]  product
);

   logic signed [PIX_W:0]        pix_s;
   logic signed [PIX_W+COEF_W:0] prod_full;

   assign pix_s     = {1'b0, pix};
   assign prod_full = pix_s * coef;
   assign product   = {{(ACC_W-PIX_W-COEF_W-1){prod_full[PIX_W+COEF_W]}}, prod_full};

endmodule

// File: rtl/ibex_vector_conv_unit.sv
// Sequential KxK convolution: LANES products per beat, then arithmetic shift and clamp to a pixel.
module ibex_vector_conv_unit
   import ibex_vector_conv_pkg::*;
#(
   parameter int NUM_TAPS = 9,
   parameter int LANES    = 3,
   parameter int PIX_W    = 8,
   parameter int COEF_W   = 8,
   parameter int ACC_W    = 24
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [NUM_TAPS*PIX_W-1:0] pix_i,
   input  logic [1:0]                mode_i,
   input  logic [$clog2(NUM_TAPS)-1:0] tap_sel_i,
   input  logic [4:0]                shift_i,
   input  logic                      coef_we_i,
   input  logic [$clog2(NUM_TAPS)-1:0] coef_addr_i,
   input  logic [COEF_W-1:0]         coef_wdata_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [PIX_W-1:0]          result_o,
   output logic                      sat_o,
   output logic                      busy_o
);

   localparam int BEATS  = (NUM_TAPS + LANES - 1) / LANES;
   localparam int PAD    = BEATS * LANES;
   localparam int TAP_W  = $clog2(NUM_TAPS);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W  = (PAD > 1) ? $clog2(PAD) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
   localparam logic [TAP_W:0]    TAPS_LIMIT = (TAP_W+1)'(NUM_TAPS);

   if (ACC_W < PIX_W + COEF_W + 1 + $clog2(NUM_TAPS)) begin : g_acc_check
      $error("ACC_W too narrow for NUM_TAPS products");
   end
   if (ACC_W > 64 || PIX_W > 31) begin : g_width_check
      $error("ACC_W must be <= 64 and PIX_W <= 31");
   end
   if (NUM_TAPS != SHARPEN_TAPS) begin : g_sharpen_check
      $error("sharpen preset requires NUM_TAPS == 9");
   end

   conv_state_e               state;
   logic [NUM_TAPS*PIX_W-1:0] pix_p0;
   conv_mode_e                mode_p0;
   logic [TAP_W-1:0]          tap_sel_p0;
   logic [4:0]                shift_p0;
   logic [BEAT_W-1:0]         beat_p1;
   logic signed [ACC_W-1:0]   acc_p1;
   logic [PIX_W-1:0]          result_p2;
   logic                      sat_p2;
   logic signed [COEF_W-1:0]  bank [NUM_TAPS];

   logic        [PIX_W-1:0]   tap_pix  [PAD];
   logic signed [COEF_W-1:0]  tap_coef [PAD];
   logic signed [ACC_W-1:0]   products [LANES];
   logic signed [ACC_W-1:0]   beat_sum;
   logic signed [ACC_W-1:0]   acc_next;
   logic [PIX_W:0]            clamp_word;

   // Per-tap pixel/coefficient view; padding taps past NUM_TAPS read as zero.
   for (genvar t = 0; t < PAD; t++) begin : g_tap
      if (t < NUM_TAPS) begin : g_real
         localparam int SIDX = (t < SHARPEN_TAPS) ? t : 0;
         localparam logic signed [SHARPEN_W-1:0] PRESET_RAW =
            (t < SHARPEN_TAPS) ? SHARPEN_3X3[SIDX*SHARPEN_W +: SHARPEN_W] : '0;
         localparam logic signed [COEF_W-1:0] PRESET = COEF_W'(PRESET_RAW);

         assign tap_pix[t] = pix_p0[t*PIX_W +: PIX_W];

         always_comb begin
            case (mode_p0)
               MODE_SELECT:  tap_coef[t] = (tap_sel_p0 == TAP_W'(t)) ? COEF_W'(1) : '0;
               MODE_SHARPEN: tap_coef[t] = PRESET;
               default:      tap_coef[t] = bank[t];
            endcase
         end
      end else begin : g_pad
         assign tap_pix[t]  = '0;
         assign tap_coef[t] = '0;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [IDX_W-1:0] idx;
      assign idx = IDX_W'(int'(beat_p1) * LANES + l);

      ibex_vector_conv_lane #(
         .PIX_W  (PIX_W),
         .COEF_W (COEF_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .pix     (tap_pix[idx]),
         .coef    (tap_coef[idx]),
         .product (products[l])
      );
   end

   always_comb begin
      beat_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         beat_sum = beat_sum + products[l];
      end
   end

   assign acc_next   = acc_p1 + beat_sum;
   assign clamp_word = (PIX_W+1)'(shift_clamp(64'(acc_next), shift_p0, PIX_W));

   // p0: window capture; p1: beat accumulation; p2: shifted and clamped result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         pix_p0     <= '0;
         mode_p0    <= MODE_BANK;
         tap_sel_p0 <= '0;
         shift_p0   <= '0;
         beat_p1    <= '0;
         acc_p1     <= '0;
         result_p2  <= '0;
         sat_p2     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  pix_p0     <= pix_i;
                  mode_p0    <= conv_mode_e'(mode_i);
                  tap_sel_p0 <= tap_sel_i;
                  shift_p0   <= shift_i;
                  beat_p1    <= '0;
                  acc_p1     <= '0;
                  state      <= ACCUM;
               end
            end
            ACCUM: begin
               acc_p1 <= acc_next;
               if (beat_p1 == LAST_BEAT) begin
                  result_p2 <= clamp_word[PIX_W:1];
                  sat_p2    <= clamp_word[0];
                  state     <= OUT;
               end else begin
                  beat_p1 <= beat_p1 + 1'b1;
               end
            end
            OUT: begin
               if (out_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bank writes land only while idle, so an accept in the same cycle sees the new value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int t = 0; t < NUM_TAPS; t++) bank[t] <= '0;
      end else if (state == IDLE && coef_we_i && ({1'b0, coef_addr_i} < TAPS_LIMIT)) begin
         bank[coef_addr_i] <= coef_wdata_i;
      end
   end

   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == OUT);
   assign busy_o      = (state != IDLE);
   assign result_o    = result_p2;
   assign sat_o       = sat_p2;

endmodule

// File: tb/tb_ibex_vector_conv_unit.sv
// Directed-vector bench for ibex_vector_conv_unit with hand-computed expected results.
module tb_ibex_vector_conv_unit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [71:0] pix_i;
   logic [1:0]  mode_i;
   logic [3:0]  tap_sel_i;
   logic [4:0]  shift_i;
   logic        coef_we_i;
   logic [3:0]  coef_addr_i;
   logic [7:0]  coef_wdata_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [7:0]  result_o;
   logic        sat_o;
   logic        busy_o;

   int vectors     = 0;
   int miscompares = 0;

   ibex_vector_conv_unit dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .pix_i        (pix_i),
      .mode_i       (mode_i),
      .tap_sel_i    (tap_sel_i),
      .shift_i      (shift_i),
      .coef_we_i    (coef_we_i),
      .coef_addr_i  (coef_addr_i),
      .coef_wdata_i (coef_wdata_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .result_o     (result_o),
      .sat_o        (sat_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] put(input logic [71:0] v, input int t, input logic [7:0] p);
      logic [71:0] r;
      r = v;
      r[t*8 +: 8] = p;
      return r;
   endfunction

   task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      coef_we_i = 1'b1; coef_addr_i = a; coef_wdata_i = d;
      @(posedge clk); #1;
      coef_we_i = 1'b0;
   endtask

   // lat counts clock edges from the accept edge (inclusive) to the edge after which out_valid_o is high.
   task automatic do_op(input logic [71:0] p, input logic [1:0] m, input logic [3:0] ts,
                        input logic [4:0] sh, input logic cw, input logic [3:0] ca,
                        input logic [7:0] cd, output logic [7:0] res, output logic s,
                        output int lat);
      @(negedge clk);
      pix_i = p; mode_i = m; tap_sel_i = ts; shift_i = sh;
      coef_we_i = cw; coef_addr_i = ca; coef_wdata_i = cd;
      in_valid_i = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      in_valid_i = 1'b0; coef_we_i = 1'b0;
      while (!out_valid_o && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
      end
      res = result_o;
      s   = sat_o;
      if (out_ready_i && out_valid_o) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [7:0] r; logic s; int lat;
      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; coef_we_i = 1'b0;
      pix_i = '0; mode_i = '0; tap_sel_i = '0; shift_i = '0; coef_addr_i = '0; coef_wdata_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_i = 1'b0; #1;
      vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
      vectors++; if (result_o !== 8'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result_o); end
      vectors++; if (sat_o !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      // Abort an operation mid-ACCUM.
      @(negedge clk);
      pix_i = {9{8'd50}}; mode_i = 2'd2; in_valid_i = 1'b1;
      @(posedge clk); #1 in_valid_i = 1'b0;
      @(posedge clk); #1;
      vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL accum_busy: got %b expected 1", busy_o); end
      rst_i = 1'b1; #1;
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL abort_out_valid: got %b expected 0", out_valid_o); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
      @(negedge clk); rst_i = 1'b0;
      repeat (5) @(posedge clk); #1;
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL abort_no_result: got %b expected 0", out_valid_o); end
      do_op({9{8'd50}}, 2'd0, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL empty_bank_result: got %0d expected 0", r); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL empty_bank_sat: got %b expected 0", s); end
   endtask

   task automatic test_bank_sum();
      logic [7:0] r; logic s; int lat;
      for (int i = 0; i < 9; i++) write_coef(4'(i), 8'd1);
      do_op({9{8'd10}}, 2'd0, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd90) begin miscompares++; $display("FAIL sum_result: got %0d expected 90", r); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL sum_sat: got %b expected 0", s); end
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sum_latency: got %0d expected 4", lat); end
      do_op({9{8'd10}}, 2'd3, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd90) begin miscompares++; $display("FAIL mode3_result: got %0d expected 90", r); end
   endtask

   task automatic test_saturation();
      logic [7:0] r; logic s; int lat;
      do_op({9{8'd200}}, 2'd0, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd255) begin miscompares++; $display("FAIL high_clamp_result: got %0d expected 255", r); end
      vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL high_clamp_sat: got %b expected 1", s); end
      do_op({9{8'd200}}, 2'd0, 4'd0, 5'd3, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd225) begin miscompares++; $display("FAIL shift3_result: got %0d expected 225", r); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL shift3_sat: got %b expected 0", s); end
      do_op({9{8'd200}}, 2'd0, 4'd0, 5'd31, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL shift31_pos_result: got %0d expected 0", r); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL shift31_pos_sat: got %b expected 0", s); end
   endtask

   task automatic test_sharpen();
      logic [7:0] r; logic s; int lat; logic [71:0] p;
      p = '0;
      p = put(p, 4, 8'd100);
      p = put(p, 1, 8'd120); p = put(p, 3, 8'd120); p = put(p, 5, 8'd120); p = put(p, 7, 8'd120);
      do_op(p, 2'd2, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd20) begin miscompares++; $display("FAIL sharpen_result: got %0d expected 20", r); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL sharpen_sat: got %b expected 0", s); end
      p = '0;
      p = put(p, 4, 8'd10);
      p = put(p, 1, 8'd200); p = put(p, 3, 8'd200); p = put(p, 5, 8'd200); p = put(p, 7, 8'd200);
      do_op(p, 2'd2, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL sharpen_neg_result: got %0d expected 0", r); end
      vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL sharpen_neg_sat: got %b expected 1", s); end
      do_op(p, 2'd2, 4'd0, 5'd31, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL shift31_neg_result: got %0d expected 0", r); end
      vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL shift31_neg_sat: got %b expected 1", s); end
   endtask

   task automatic test_select_backpressure();
      logic [7:0] r; logic s; int lat; logic [71:0] p;
      p = put({9{8'd99}}, 6, 8'd77);
      do_op(p, 2'd1, 4'd12, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0 || s !== 1'b0) begin miscompares++; $display("FAIL select_oob: got %0d/%b expected 0/0", r, s); end
      @(negedge clk); out_ready_i = 1'b0;
      do_op(p, 2'd1, 4'd6, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd77) begin miscompares++; $display("FAIL select_result: got %0d expected 77", r); end
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL select_latency: got %0d expected 4", lat); end
      @(negedge clk);
      coef_we_i = 1'b1; coef_addr_i = 4'd0; coef_wdata_i = 8'd50;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         coef_we_i = 1'b0;
         vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid_o); end
         vectors++; if (result_o !== 8'd77) begin miscompares++; $display("FAIL hold_result[%0d]: got %0d expected 77", i, result_o); end
         vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready_o); end
      end
      @(negedge clk); out_ready_i = 1'b1;
      @(posedge clk); #1;
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL release_valid: got %b expected 0", out_valid_o); end
      vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready_o); end
      p = put(72'd0, 0, 8'd1);
      do_op(p, 2'd0, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd1) begin miscompares++; $display("FAIL busy_write_ignored: got %0d expected 1", r); end
   endtask

   task automatic test_coef_write_accept();
      logic [7:0] r; logic s; int lat; logic [71:0] p;
      for (int i = 1; i < 9; i++) write_coef(4'(i), 8'd0);
      p = put(72'd0, 0, 8'd10);
      do_op(p, 2'd0, 4'd0, 5'd0, 1'b1, 4'd0, 8'hFD, r, s, lat);
      vectors++; if (r !== 8'd0) begin miscompares++; $display("FAIL same_cycle_write_result: got %0d expected 0", r); end
      vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL same_cycle_write_sat: got %b expected 1", s); end
      write_coef(4'd12, 8'd100);
      do_op({9{8'd10}}, 2'd0, 4'd0, 5'd0, 1'b0, 4'd0, 8'd0, r, s, lat);
      vectors++; if (r !== 8'd0 || s !== 1'b1) begin miscompares++; $display("FAIL oob_write_ignored: got %0d/%b expected 0/1", r, s); end
   endtask

   initial begin
      test_reset();
      test_bank_sum();
      test_saturation();
      test_sharpen();
      test_select_backpressure();
      test_coef_write_accept();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ibex_vector_conv_unit.md
Name: ibex_vector_conv_unit

Overview:
- Parametrised, sequential successor to the 9-lane combinational vector MAC filter.
- Accepts one KxK window of unsigned pixels over a valid/ready handshake.
- Time-multiplexes LANES signed multiply-add lanes over the taps, then applies an arithmetic right shift and clamps to an unsigned pixel.
- Holds the result under output backpressure. Sits between the vector register read path and writeback.

Parameters:
NUM_TAPS, 9, window taps (K*K)
LANES, 3, products accumulated per cycle; BEATS = ceil(NUM_TAPS/LANES)
PIX_W, 8, unsigned pixel width
COEF_W, 8, signed coefficient width
ACC_W, 24, signed accumulator width; elaboration check ACC_W >= PIX_W+COEF_W+1+$clog2(NUM_TAPS)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  window valid
in_ready_o  out  1  unit can accept a window
pix_i  in  NUM_TAPS*PIX_W  packed pixels, tap t at [t*PIX_W +: PIX_W]
mode_i  in  2  0 = coefficient bank, 1 = single-tap select, 2 = preset sharpen, 3 = same as 0
tap_sel_i  in  $clog2(NUM_TAPS)  tap used in mode 1
shift_i  in  5  arithmetic right shift applied before clamp
coef_we_i  in  1  coefficient write strobe
coef_addr_i  in  $clog2(NUM_TAPS)  coefficient index
coef_wdata_i  in  COEF_W  signed coefficient
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  PIX_W  clamped result
sat_o  out  1  clamp occurred for this result
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; in_ready_o=1; out_valid_o, result_o, sat_o, busy_o = 0; accumulator = 0; coefficient bank all 0.
- Reset asserted in any state aborts the operation immediately; the partial result is discarded.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, register pix_i, mode_i, tap_sel_i and shift_i; clear the accumulator and beat counter; go to ACCUM.
- ACCUM:
  - Runs for BEATS cycles. Beat b adds taps b*LANES .. b*LANES+LANES-1.
  - Tap indices >= NUM_TAPS contribute 0.
  - After the last beat, go to OUT. The shifted, clamped result is registered on that same edge.
- Latency: out_valid_o rises BEATS+1 cycles after the accept edge (4 with defaults).
- OUT:
  - out_valid_o=1. result_o and sat_o stay stable until out_valid_o & out_ready_i.
  - On that handshake, go to IDLE and drop out_valid_o.
  - in_ready_o=0 in ACCUM and OUT, so throughput is one window per BEATS+2 cycles.
- Arithmetic:
  - Pixel is zero-extended to PIX_W+1 and treated as signed; coefficient is signed.
  - Product is sign-extended to ACC_W.
  - Final value = acc >>> shift_i.
  - If final < 0: result 0, sat 1. If final > 2^PIX_W-1: result all-ones, sat 1. Otherwise result = final[PIX_W-1:0], sat 0.
- Coefficient source per tap:
  - Mode 0/3: bank[t].
  - Mode 1: 1 if t==tap_sel, else 0.
  - Mode 2: package preset (index 4 = +5; indices 1,3,5,7 = -1; others 0). Elaboration error if NUM_TAPS != 9.
- Coefficient writes:
  - Accepted only when the state is IDLE.
  - Ignored when busy, and ignored when coef_addr_i >= NUM_TAPS.
  - A write in the same cycle as an input accept commits at that edge, so it is used by the accepted operation.
- tap_sel_i >= NUM_TAPS in mode 1: all coefficients 0, result 0.
- shift_i >= ACC_W: result is the sign fill (0 or -1 → clamps to 0 with sat 1 when negative).

Decomposition:
- Package ibex_vector_conv_pkg holds:
  - the conv_mode_e enum;
  - the conv_state_e enum (IDLE, ACCUM, OUT);
  - the SHARPEN_3X3 coefficient constant;
  - the clamp/shift helper function.
- Sub-module ibex_vector_conv_lane: combinational unsigned-pixel × signed-coefficient product, sign-extended to ACC_W. Instantiated LANES times in a generate loop; the top owns the FSM, counter, accumulator and bank.

Test Plan:
1. Reset, then release → in_ready_o=1, out_valid_o=0, result_o=0. Assert rst_i mid-ACCUM → out_valid_o=0 immediately; after release, an op with the unwritten bank gives result 0.
2. Write bank all 1; pixels all 10; shift 0; mode 0 → result 90, sat 0; out_valid_o exactly 4 cycles after accept.
3. Bank all 1; pixels all 200 → 1800 gives 255, sat 1. Same with shift 3 → 225, sat 0.
4. Mode 2, centre 100, taps 1,3,5,7 = 120, rest 0 → 20, sat 0. Centre 10, neighbours 200 → 0, sat 1.
5. Mode 1, tap_sel 6, pixel6=77 → 77. Hold out_ready_i low 5 cycles → result_o and out_valid_o stable, in_ready_o=0. Coefficient write during busy is ignored (verify on the next mode-0 op).
6. Bank write addr 0 = -3 in the same cycle as accept, pixel0=10, other coefficients 0 → 0, sat 1. Write to addr 12 is ignored.
